// File: rtl/uart_beat_tx.sv
// uart_beat_tx: sends a 3-byte 8N1 frame (0x42, seq, 0x0A) on each rising edge of trig.
// A trig edge seen while a frame is in flight is discarded and flagged on drop.
module uart_beat_tx #(
  parameter int unsigned CLK_HZ   = 50_000_000,
  parameter int unsigned BAUD     = 9600,
  parameter int unsigned BAUD_DIV = CLK_HZ / BAUD
) (
  input  logic       sclk,
  input  logic       s_rst,
  input  logic       trig,
  output logic       tx,
  output logic       busy,
  output logic       drop,
  output logic [7:0] seq
);

  if (BAUD_DIV < 2) begin : g_bad_div
    $error("uart_beat_tx: BAUD_DIV must be >= 2");
  end

  localparam int unsigned CntW = (BAUD_DIV > 2) ? $clog2(BAUD_DIV) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(BAUD_DIV - 1);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StStart = 2'd1;
  localparam logic [1:0] StData  = 2'd2;
  localparam logic [1:0] StStop  = 2'd3;

  logic            s1_q, s2_q, s3_q;
  logic            vld1_q, vld2_q;
  logic            armed_q, armed_d;
  logic            strobe;
  logic [1:0]      state_q, state_d;
  logic [CntW-1:0] baud_cnt_q, baud_cnt_d;
  logic [2:0]      bit_idx_q, bit_idx_d;
  logic [1:0]      byte_idx_q, byte_idx_d;
  logic [7:0]      seq_lat_q, seq_lat_d;
  logic [7:0]      seq_q, seq_d;
  logic            tx_q, tx_d;
  logic            drop_q, drop_d;
  logic            bit_end;
  logic [7:0]      byte_sel;

  // Synchronizer, edge history, and tracking of real (post-reset) samples in s2.
  always_ff @(posedge sclk) begin
    if (s_rst) begin
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      s3_q    <= 1'b0;
      vld1_q  <= 1'b0;
      vld2_q  <= 1'b0;
      armed_q <= 1'b0;
    end else begin
      s1_q    <= trig;
      s2_q    <= s1_q;
      s3_q    <= s2_q;
      vld1_q  <= 1'b1;
      vld2_q  <= vld1_q;
      armed_q <= armed_d;
    end
  end

  // Only arm once s2 has held a genuinely sampled low, so a trig already high at reset
  // release does not look like an edge.
  assign armed_d = armed_q | (vld2_q & ~s2_q);
  assign strobe  = s2_q & ~s3_q & armed_q;
  assign bit_end = (baud_cnt_q == CntMax);

  // Frame sequencer next-state logic.
  always_comb begin
    state_d    = state_q;
    baud_cnt_d = baud_cnt_q;
    bit_idx_d  = bit_idx_q;
    byte_idx_d = byte_idx_q;
    seq_lat_d  = seq_lat_q;
    seq_d      = seq_q;
    drop_d     = strobe && (state_q != StIdle);
    case (state_q)
      StIdle: begin
        baud_cnt_d = '0;
        if (strobe) begin
          byte_idx_d = 2'd0;
          bit_idx_d  = 3'd0;
          seq_lat_d  = seq_q;
          seq_d      = seq_q + 8'd1;
          state_d    = StStart;
        end
      end
      StStart: begin
        if (bit_end) begin
          baud_cnt_d = '0;
          bit_idx_d  = 3'd0;
          state_d    = StData;
        end else begin
          baud_cnt_d = baud_cnt_q + CntW'(1);
        end
      end
      StData: begin
        if (bit_end) begin
          baud_cnt_d = '0;
          if (bit_idx_q == 3'd7) begin
            state_d = StStop;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end else begin
          baud_cnt_d = baud_cnt_q + CntW'(1);
        end
      end
      StStop: begin
        if (bit_end) begin
          baud_cnt_d = '0;
          if (byte_idx_q < 2'd2) begin
            byte_idx_d = byte_idx_q + 2'd1;
            state_d    = StStart;
          end else begin
            state_d = StIdle;
          end
        end else begin
          baud_cnt_d = baud_cnt_q + CntW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Line level is decoded from the next state so tx comes straight from a flop.
  always_comb begin
    byte_sel = 8'h0A;
    tx_d     = 1'b1;
    if (byte_idx_d == 2'd0) begin
      byte_sel = 8'h42;
    end else if (byte_idx_d == 2'd1) begin
      byte_sel = seq_lat_d;
    end
    if (state_d == StStart) begin
      tx_d = 1'b0;
    end else if (state_d == StData) begin
      tx_d = byte_sel[bit_idx_d];
    end
  end

  // Sequencer and output registers.
  always_ff @(posedge sclk) begin
    if (s_rst) begin
      state_q    <= StIdle;
      baud_cnt_q <= '0;
      bit_idx_q  <= 3'd0;
      byte_idx_q <= 2'd0;
      seq_lat_q  <= 8'h00;
      seq_q      <= 8'h00;
      tx_q       <= 1'b1;
      drop_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      baud_cnt_q <= baud_cnt_d;
      bit_idx_q  <= bit_idx_d;
      byte_idx_q <= byte_idx_d;
      seq_lat_q  <= seq_lat_d;
      seq_q      <= seq_d;
      tx_q       <= tx_d;
      drop_q     <= drop_d;
    end
  end

  assign tx   = tx_q;
  assign busy = (state_q != StIdle);
  assign drop = drop_q;
  assign seq  = seq_q;

endmodule

// File: tb/tb_uart_beat_tx.sv
// Bench for uart_beat_tx: directed steps, serial decoder feeding a byte scoreboard.
module tb_uart_beat_tx;

  localparam int D = 10;

  logic       sclk;
  logic       s_rst;
  logic       trig;
  logic       tx;
  logic       busy;
  logic       drop;
  logic [7:0] seq;

  int checks;
  int failures;
  int drop_cycles;
  logic [7:0] exp_seq;
  logic [7:0] sb_q[$];

  uart_beat_tx #(
    .CLK_HZ(1000),
    .BAUD  (100)
  ) dut (
    .sclk (sclk),
    .s_rst(s_rst),
    .trig (trig),
    .tx   (tx),
    .busy (busy),
    .drop (drop),
    .seq  (seq)
  );

  initial begin
    sclk = 1'b0;
    forever #5 sclk = ~sclk;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp)
    else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic push_frame();
    sb_q.push_back(8'h42);
    sb_q.push_back(exp_seq);
    sb_q.push_back(8'h0A);
    exp_seq = exp_seq + 8'd1;
  endtask

  task automatic do_reset();
    @(posedge sclk);
    #1 s_rst = 1'b1;
    repeat (3) @(posedge sclk);
    #1 s_rst = 1'b0;
    sb_q.delete();
    exp_seq = 8'h00;
  endtask

  task automatic wait_idle(input string tag);
    int cnt;
    cnt = 0;
    while (busy && cnt < 400) begin
      cnt++;
      @(negedge sclk);
    end
    chk(tag, busy, 0);
  endtask

  // Serial decoder: samples each bit at its centre and checks bytes against the scoreboard.
  initial begin : monitor
    bit       rx_on;
    int       rx_c;
    logic [7:0] rx_byte;
    logic [7:0] exp_b;
    rx_on = 0;
    rx_c  = 0;
    rx_byte = 8'h00;
    forever begin
      @(negedge sclk);
      if (drop === 1'b1) drop_cycles++;
      if (s_rst) begin
        rx_on = 0;
      end else if (!rx_on) begin
        if (tx === 1'b0) begin
          rx_on = 1;
          rx_c  = 0;
        end
      end else begin
        rx_c++;
        if (rx_c > D && rx_c < 9 * D && (rx_c % D) == D / 2) rx_byte[(rx_c - D) / D] = tx;
        if (rx_c == 9 * D + D / 2) begin
          chk("rx_stop_bit", tx, 1);
          chk("rx_byte_expected", (sb_q.size() != 0), 1);
          if (sb_q.size() != 0) begin
            exp_b = sb_q.pop_front();
            chk("rx_byte", rx_byte, exp_b);
          end
          rx_on = 0;
        end
      end
    end
  end

  initial begin : stim
    int cnt;
    int dsnap;
    checks      = 0;
    failures    = 0;
    drop_cycles = 0;
    exp_seq     = 8'h00;
    s_rst       = 1'b1;
    trig        = 1'b0;

    // Reset state and idle line
    repeat (3) @(posedge sclk);
    #1 s_rst = 1'b0;
    @(negedge sclk);
    chk("rst_tx", tx, 1);
    chk("rst_busy", busy, 0);
    chk("rst_drop", drop, 0);
    chk("rst_seq", seq, 8'h00);
    cnt = 0;
    repeat (100) begin
      @(negedge sclk);
      if (tx !== 1'b1) cnt++;
    end
    chk("idle_tx_low_cycles", cnt, 0);

    // Single beat with exact latency and frame length
    @(posedge sclk);
    #1 trig = 1'b1;
    push_frame();
    @(posedge sclk);  // N
    @(posedge sclk);  // N+1
    @(negedge sclk);
    chk("beat_busy_pre", busy, 0);
    chk("beat_tx_pre", tx, 1);
    @(posedge sclk);  // N+2
    @(negedge sclk);
    chk("beat_tx_start", tx, 0);
    chk("beat_busy_start", busy, 1);
    chk("beat_seq_inc", seq, 8'h01);
    cnt = 0;
    while (busy && cnt < 400) begin
      cnt++;
      @(negedge sclk);
    end
    chk("beat_busy_len", cnt, 300);
    chk("beat_tx_end", tx, 1);
    chk("beat_sb_empty", sb_q.size(), 0);
    chk("beat_seq_after", seq, 8'h01);

    // Mid-frame retrigger is dropped
    @(posedge sclk);
    #1 trig = 1'b0;
    do_reset();
    repeat (5) @(posedge sclk);
    dsnap = drop_cycles;
    #1 trig = 1'b1;
    push_frame();
    repeat (20) @(posedge sclk);
    #1 trig = 1'b0;
    repeat (50) @(posedge sclk);
    #1 trig = 1'b1;
    @(negedge sclk);
    wait_idle("drop_frame_done");
    chk("drop_pulse_cycles", drop_cycles - dsnap, 1);
    chk("drop_sb_empty", sb_q.size(), 0);
    chk("drop_seq", seq, 8'h01);

    // Sequence wrap over 257 beats
    @(posedge sclk);
    #1 trig = 1'b0;
    do_reset();
    repeat (5) @(posedge sclk);
    for (int i = 0; i < 257; i++) begin
      #1 trig = 1'b1;
      push_frame();
      repeat (150) @(posedge sclk);
      #1 trig = 1'b0;
      repeat (160) @(posedge sclk);
    end
    @(negedge sclk);
    wait_idle("wrap_done");
    chk("wrap_sb_empty", sb_q.size(), 0);
    chk("wrap_seq", seq, 8'h01);

    // Reset mid-frame, trig held high through release
    @(posedge sclk);
    #1 trig = 1'b1;
    push_frame();
    @(posedge sclk);  // N
    @(posedge sclk);  // N+1
    @(posedge sclk);  // N+2
    repeat (150) @(posedge sclk);
    #1 s_rst = 1'b1;
    sb_q.delete();
    @(posedge sclk);
    @(negedge sclk);
    chk("mrst_tx", tx, 1);
    chk("mrst_busy", busy, 0);
    chk("mrst_seq", seq, 8'h00);
    @(posedge sclk);
    #1 s_rst = 1'b0;
    exp_seq = 8'h00;
    cnt = 0;
    repeat (20) begin
      @(negedge sclk);
      if (busy !== 1'b0) cnt++;
    end
    chk("mrst_no_edge_release", cnt, 0);
    @(posedge sclk);
    #1 trig = 1'b0;
    repeat (5) @(posedge sclk);
    #1 trig = 1'b1;
    push_frame();
    repeat (5) @(posedge sclk);
    @(negedge sclk);
    wait_idle("mrst_frame_done");
    chk("mrst_sb_empty", sb_q.size(), 0);

    // Strobe on the last stop cycle of byte 2 is dropped
    @(posedge sclk);
    #1 trig = 1'b0;
    repeat (5) @(posedge sclk);
    #1 trig = 1'b1;
    push_frame();
    @(posedge sclk);  // N
    repeat (20) @(posedge sclk);
    #1 trig = 1'b0;
    repeat (279) @(posedge sclk);  // N+299
    #1 trig = 1'b1;
    @(posedge sclk);  // N+300
    @(posedge sclk);  // N+301
    @(posedge sclk);  // N+302
    @(negedge sclk);
    chk("bnd_drop_hi", drop, 1);
    chk("bnd_busy_end", busy, 0);
    @(negedge sclk);
    chk("bnd_drop_lo", drop, 0);
    cnt = 0;
    repeat (20) begin
      @(negedge sclk);
      if (busy !== 1'b0) cnt++;
    end
    chk("bnd_no_new_frame", cnt, 0);
    chk("bnd_seq", seq, exp_seq);
    chk("bnd_sb_empty", sb_q.size(), 0);

    // Strobe one cycle later, in IDLE, starts a frame
    @(posedge sclk);
    #1 trig = 1'b0;
    repeat (5) @(posedge sclk);
    #1 trig = 1'b1;
    push_frame();
    @(posedge sclk);  // N
    repeat (20) @(posedge sclk);
    #1 trig = 1'b0;
    repeat (280) @(posedge sclk);  // N+300
    #1 trig = 1'b1;
    push_frame();
    @(posedge sclk);  // N+301
    @(posedge sclk);  // N+302
    @(negedge sclk);
    chk("bnd2_busy_gap", busy, 0);
    @(posedge sclk);  // N+303
    @(negedge sclk);
    chk("bnd2_busy_start", busy, 1);
    chk("bnd2_tx_start", tx, 0);
    chk("bnd2_drop", drop, 0);
    wait_idle("bnd2_frame_done");
    chk("bnd2_sb_empty", sb_q.size(), 0);
    chk("bnd2_seq", seq, exp_seq);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_beat_tx.md
# uart_beat_tx

UART heartbeat transmitter that consumes the square-wave output of the on-board periodic timer (`timer_1s.io_pin`). On every rising edge of that signal it sends a fixed 3-byte frame over an 8N1 serial line: header 0x42, an 8-bit sequence number, then 0x0A. It sits between the timer and the board's UART TX pin and provides a visible, countable once-per-period beat on the host terminal.

## Interface
- `CLK_HZ`, default 50_000_000: sclk frequency in Hz.
- `BAUD`, default 9600: serial bit rate.
- `BAUD_DIV`, default CLK_HZ/BAUD (integer divide, 5208 at defaults): sclk cycles per bit. Must be ≥ 2; the implementation elaborates with an error otherwise.

- `sclk` input 1: system clock. One clock domain; every flop is on posedge sclk.
- `s_rst` input 1: reset, synchronous and active-high.
- `trig` input 1: beat request, the timer square wave. Treated as asynchronous.
- `tx` output 1: serial data, idle high.
- `busy` output 1: high while a frame is being shifted out.
- `drop` output 1: one-cycle pulse when a trig rising edge arrives while busy.
- `seq` output 8: sequence number the next frame will carry.

## Operation
- trig passes through a 2-flop synchronizer (s1, s2) and a third history flop s3. The edge strobe is s2 & ~s3.
- FSM states and transitions:
  - IDLE: tx=1. On the edge strobe, load byte index 0, clear the bit and baud counters, latch the frame sequence byte from seq, increment seq, and go to START.
  - START: tx=0 for BAUD_DIV cycles, then go to DATA.
  - DATA: 8 bits, LSB first, BAUD_DIV cycles each, then go to STOP.
  - STOP: tx=1 for BAUD_DIV cycles. If byte index < 2, increment it and go to START. Otherwise go to IDLE.
- Frame bytes by index: 0 is 0x42, 1 is the latched sequence byte, 2 is 0x0A. Bytes are sent back to back with no inter-byte idle.
- busy=1 in every state except IDLE.
- drop: asserts for one cycle when the edge strobe is seen in any state other than IDLE. The event is otherwise discarded; no queueing and no seq change. An edge strobe in the same cycle the FSM is completing STOP of byte 2 counts as busy, so it is dropped.
- seq increments modulo 256; after 0xFF comes 0x00. The first frame after reset carries 0x00.
- Baud counter runs 0..BAUD_DIV-1. It is reset on every bit transition, so each bit lasts exactly BAUD_DIV cycles.

## Timing
- Reset values: tx=1, busy=0, drop=0, seq=0x00. Also s1=s2=s3=0 and FSM=IDLE.
- s_rst asserted mid-frame: on the next sclk edge tx returns to 1, busy=0, seq=0x00, and the frame is abandoned. A trig that is already high at reset release produces no edge. An edge requires a 0→1 change to be seen by s2/s3 after reset.
- Latency: let N be the sclk edge at which s1 first captures trig=1. Then:
  - s2=1 at N+1.
  - The strobe is valid during the cycle after N+1.
  - tx=0 and busy=1 are registered at edge N+2.
  - seq has its incremented value from N+2.
- Frame length is exactly 30·BAUD_DIV cycles. busy falls, with tx still 1, at edge N+2+30·BAUD_DIV.
- Bit k of the frame (k=0..29) occupies edges N+2+k·BAUD_DIV to N+2+(k+1)·BAUD_DIV-1.
- drop is high for the single cycle following the edge that registers the strobe in a non-IDLE state.
- trig pulses shorter than 2 sclk cycles are not guaranteed to be detected.

## Test plan
Bench parameters: CLK_HZ=1000, BAUD=100, giving BAUD_DIV=10.

- Reset: hold s_rst for 3 cycles, then release. Required: tx=1, busy=0, drop=0, seq=0x00; tx stays 1 for 100 idle cycles with trig=0.
- Single beat: raise trig and hold it. Required:
  - tx=0 at N+2.
  - Decoded serial stream is 0x42, 0x00, 0x0A with stop bits high.
  - busy high for exactly 300 cycles.
  - seq=0x01 from N+2 onward.
- Drop: raise trig, drop it 20 cycles later, raise it again 50 cycles after that, mid-frame. Required: one drop pulse of 1 cycle; the frame is unchanged; seq remains 0x01 after the frame.
- Wrap: issue 257 spaced beats, each ≥ 310 cycles apart. Required: sequence bytes 0x00…0xFF, then 0x00; seq=0x01 at the end.
- Reset mid-frame: assert s_rst at cycle 150 of a frame. Required: tx=1 and busy=0 on the next edge, seq=0x00. The next beat sends 0x42, 0x00, 0x0A.
- Back-to-back boundary: place a trig edge so its strobe coincides with the last STOP cycle of byte 2. Required: drop pulses and no new frame starts. An edge strobed one cycle later (in IDLE) starts a frame.
